// File: rtl/udp_packer_pkg.sv
// Shared types and constants for the UDP sample packer.
// Issue-FSM states, pack-slot encodings and the packet header magic.
package udp_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_GUARD,
        ST_FLUSH,
        ST_FGUARD
    } issue_state_e;

    localparam logic [15:0] HEADER_MAGIC = 16'hA55A;

    localparam logic [1:0] SLOT_HI  = 2'd0;
    localparam logic [1:0] SLOT_MID = 2'd1;
    localparam logic [1:0] SLOT_LO  = 2'd2;

    // Zero the slots that have not been filled yet.
    function automatic logic [47:0] pad_word(
        input logic [47:0] word,
        input logic [1:0]  slot
    );
        logic [47:0] w_out;
        w_out = word;
        if (slot == SLOT_MID) begin
            w_out = {word[47:32], 32'h0};
        end else if (slot == SLOT_LO) begin
            w_out = {word[47:16], 16'h0};
        end
        return w_out;
    endfunction

endpackage

// File: rtl/packer_word_fifo.sv
// Synchronous show-ahead FIFO for packed 48-bit words.
// rd_data always presents the oldest entry while the FIFO is not empty.
module packer_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [47:0]            wr_data,
    input  logic                   rd_en,
    output logic [47:0]            rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [47:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign full    = (r_count == FULL_CNT);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rptr];
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/udp_sample_packer.sv
// Packs 16-bit samples three per 48-bit word and streams them to the W5500 UDP controller.
// Define UDP_PACKER_SEQ_HEADER_EN to prefix each packet with {A55A, seq[31:0]}.
module udp_sample_packer
    import udp_packer_pkg::*;
#(
    parameter int WORDS_PER_PACKET = 40,
    parameter int FIFO_DEPTH       = 8,
    parameter int FLUSH_TIMEOUT    = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    output logic        sample_ready,
    input  logic        wiz_available,
    output logic        wiz_data_valid,
    output logic [47:0] wiz_data,
    output logic        wiz_flush_requested,
    output logic [15:0] dropped_count,
    output logic [15:0] packets_sent
);
    localparam int WCW = $clog2(WORDS_PER_PACKET + 1);
    localparam int TCW = $clog2(FLUSH_TIMEOUT);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
`ifdef UDP_PACKER_SEQ_HEADER_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif

    issue_state_e   r_state;
    issue_state_e   w_next;
    logic [1:0]     r_slot;
    logic [47:0]    r_word;
    logic           r_wr_en;
    logic [47:0]    r_wr_data;
    logic [WCW-1:0] r_words;
    logic [TCW-1:0] r_tcnt;
    logic           r_tflush;
    logic [15:0]    r_drop;
    logic [15:0]    r_pkts;
    logic           r_valid;
    logic [47:0]    r_data;
    logic           r_flush;

    logic [47:0]    w_fifo_rd;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [CW-1:0]  w_fifo_count;
    logic           w_pop;
    logic           w_accept;
    logic           w_pad;
    logic           w_pkt_full;
    logic           w_has_data;
    logic           w_drained;
    logic           w_tflush_go;
    logic           w_tflush_clr;
    logic           w_pending;
    logic           w_fire;
    logic           w_need_hdr;
    logic [47:0]    w_push_word;

    packer_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (r_wr_en),
        .wr_data (r_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    assign w_pkt_full = (r_words == WCW'(WORDS_PER_PACKET));
    assign w_has_data = (r_words > WCW'(HDR_WORDS));
    assign w_drained  = (w_fifo_count == '0) && !r_wr_en;

    // A pending timeout closes the partial word before packing resumes.
    assign w_pad = r_tflush && (r_slot != SLOT_HI) && !w_fifo_full && !r_wr_en;
    assign sample_ready = !w_pad && !((r_slot == SLOT_LO) && w_fifo_full);
    assign w_accept = sample_valid && sample_ready;

    assign w_tflush_go  = r_tflush && w_drained && (r_slot == SLOT_HI) && w_has_data;
    assign w_tflush_clr = r_tflush && w_drained && (r_slot == SLOT_HI) && !w_has_data;

    assign w_pending = (r_state == ST_IDLE) && !r_tflush &&
                       (w_has_data || (r_slot != SLOT_HI));
    assign w_fire    = w_pending && (r_tcnt == TCW'(FLUSH_TIMEOUT - 1));

`ifdef UDP_PACKER_SEQ_HEADER_EN
    logic [31:0] r_seq;

    assign w_need_hdr  = (r_words == '0);
    assign w_push_word = w_need_hdr ? {HEADER_MAGIC, r_seq} : w_fifo_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_seq <= r_seq + 32'd1;
        end
    end
`else
    assign w_need_hdr  = 1'b0;
    assign w_push_word = w_fifo_rd;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot    <= SLOT_HI;
            r_word    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_pad) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= pad_word(r_word, r_slot);
                r_slot    <= SLOT_HI;
            end else if (w_accept) begin
                unique case (r_slot)
                    SLOT_HI: begin
                        r_word[47:32] <= sample;
                        r_slot        <= SLOT_MID;
                    end
                    SLOT_MID: begin
                        r_word[31:16] <= sample;
                        r_slot        <= SLOT_LO;
                    end
                    default: begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= {r_word[47:16], sample};
                        r_slot    <= SLOT_HI;
                    end
                endcase
            end
        end
    end

    // Full-packet flush outranks a pop so a packet never overruns.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (wiz_available) begin
                    if (w_pkt_full) begin
                        w_next = ST_FLUSH;
                    end else if (!w_fifo_empty) begin
                        w_next = ST_PUSH;
                        w_pop  = !w_need_hdr;
                    end else if (w_tflush_go) begin
                        w_next = ST_FLUSH;
                    end
                end
            end
            ST_PUSH:  w_next = ST_GUARD;
            ST_GUARD: w_next = ST_IDLE;
            ST_FLUSH: w_next = ST_FGUARD;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_flush <= 1'b0;
            r_words <= '0;
            r_pkts  <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == ST_PUSH);
            r_flush <= (w_next == ST_FLUSH);
            if (w_next == ST_PUSH) begin
                r_data <= w_push_word;
            end
            if (r_state == ST_PUSH) begin
                r_words <= r_words + WCW'(1);
            end else if (r_state == ST_FLUSH) begin
                r_words <= '0;
                r_pkts  <= r_pkts + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt   <= '0;
            r_tflush <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_accept || (r_state == ST_PUSH) || w_fire) begin
                r_tcnt <= '0;
            end else if (w_pending) begin
                r_tcnt <= r_tcnt + TCW'(1);
            end
            if (r_state == ST_FLUSH) begin
                r_tflush <= 1'b0;
            end else if (w_fire) begin
                r_tflush <= 1'b1;
            end else if (w_tflush_clr) begin
                r_tflush <= 1'b0;
            end
            if (sample_valid && !sample_ready && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign wiz_data_valid      = r_valid;
    assign wiz_data            = r_data;
    assign wiz_flush_requested = r_flush;
    assign dropped_count       = r_drop;
    assign packets_sent        = r_pkts;

endmodule

// File: tb/tb_udp_sample_packer.sv
// Self-checking bench for udp_sample_packer.
// Compares the observed push/flush event stream against a packet-level model.
module tb_udp_sample_packer;
    localparam int WPP   = 40;
    localparam int DEPTH = 8;
    localparam int TO    = 64;
`ifdef UDP_PACKER_SEQ_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam logic [48:0] FLUSH_EV = {1'b1, 48'h0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;
    logic        sample_ready;
    logic        wiz_available = 1'b0;
    logic        wiz_data_valid;
    logic [47:0] wiz_data;
    logic        wiz_flush_requested;
    logic [15:0] dropped_count;
    logic [15:0] packets_sent;

    always #5 clk = ~clk;

    udp_sample_packer #(
        .WORDS_PER_PACKET (WPP),
        .FIFO_DEPTH       (DEPTH),
        .FLUSH_TIMEOUT    (TO)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .sample_valid        (sample_valid),
        .sample              (sample),
        .sample_ready        (sample_ready),
        .wiz_available       (wiz_available),
        .wiz_data_valid      (wiz_data_valid),
        .wiz_data            (wiz_data),
        .wiz_flush_requested (wiz_flush_requested),
        .dropped_count       (dropped_count),
        .packets_sent        (packets_sent)
    );

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    bit wiz_pat = 1'b0;
    logic [48:0] mon_q[$];
    int          mon_t[$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (wiz_data_valid) begin
                mon_q.push_back({1'b0, wiz_data});
                mon_t.push_back(cyc_n);
            end
            if (wiz_flush_requested) begin
                mon_q.push_back(FLUSH_EV);
                mon_t.push_back(cyc_n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (wiz_pat) wiz_available = (cyc_n % 4) != 3;
    endtask

    task automatic send(input logic [15:0] v);
        sample_valid = 1'b1;
        sample = v;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sample_valid = 1'b0;
        wiz_pat = 1'b0;
        wiz_available = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        mon_q.delete();
        mon_t.delete();
    endtask

    // Packet-level model: words of three samples, zero padded at the tail,
    // optional header per packet, flush on full packet or leftover tail.
    task automatic build_exp(input logic [15:0] acc[$],
                             output logic [48:0] exp[$], output int npk);
        int cnt;
        int unsigned seq;
        cnt = 0;
        seq = 0;
        npk = 0;
        exp = {};
        for (int i = 0; i < acc.size(); i += 3) begin
            logic [15:0] a, b, c;
            a = acc[i];
            b = (i + 1 < acc.size()) ? acc[i+1] : 16'h0;
            c = (i + 2 < acc.size()) ? acc[i+2] : 16'h0;
            if (HDR != 0 && cnt == 0) begin
                exp.push_back({1'b0, 16'hA55A, seq});
                cnt++;
            end
            exp.push_back({1'b0, a, b, c});
            cnt++;
            if (cnt == WPP) begin
                exp.push_back(FLUSH_EV);
                cnt = 0;
                seq++;
                npk++;
            end
        end
        if (cnt > 0) begin
            exp.push_back(FLUSH_EV);
            npk++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sample_valid = 1'b0;
        wiz_available = 1'b1;
        repeat (2) step();
        checks++;
        if (wiz_data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", wiz_data_valid); end
        checks++;
        if (wiz_data !== 48'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", wiz_data); end
        checks++;
        if (wiz_flush_requested !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", wiz_flush_requested); end
        checks++;
        if (dropped_count !== 16'h0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", dropped_count); end
        checks++;
        if (packets_sent !== 16'h0) begin failures++; $display("FAIL rst_pkts got=%0d exp=0", packets_sent); end
        checks++;
        if (sample_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", sample_ready); end
        reset_n = 1'b1;
        repeat (TO + 20) step();
        checks++;
        if (mon_q.size() != 0) begin failures++; $display("FAIL rst_idle_events got=%0d exp=0", mon_q.size()); end
    endtask

    task automatic test_basic();
        logic [15:0] acc[$];
        logic [48:0] exp[$];
        int npk;
        do_reset();
        wiz_available = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            acc.push_back(16'(i));
            send(16'(i));
        end
        repeat (TO + 40) step();
        build_exp(acc, exp, npk);
        checks++;
        if (mon_q.size() != exp.size()) begin failures++; $display("FAIL basic_events got=%0d exp=%0d", mon_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp[i]) begin failures++; $display("FAIL basic_ev%0d got=%h exp=%h", i, mon_q[i], exp[i]); end
        end
        for (int i = 1; i < mon_t.size(); i++) begin
            checks++;
            if (mon_t[i] - mon_t[i-1] < 3) begin failures++; $display("FAIL basic_gap%0d got=%0d exp>=3", i, mon_t[i] - mon_t[i-1]); end
        end
        checks++;
        if (packets_sent !== 16'(npk)) begin failures++; $display("FAIL basic_pkts got=%0d exp=%0d", packets_sent, npk); end
    endtask

    task automatic test_full_packet();
        logic [15:0] acc[$];
        logic [48:0] exp[$];
        int npk;
        logic [15:0] v;
        do_reset();
        wiz_available = 1'b1;
        for (int i = 0; i < 3 * WPP; i++) begin
            v = 16'($urandom);
            acc.push_back(v);
            send(v);
        end
        repeat (TO + 60) step();
        build_exp(acc, exp, npk);
        checks++;
        if (mon_q.size() != exp.size()) begin failures++; $display("FAIL full_events got=%0d exp=%0d", mon_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp[i]) begin failures++; $display("FAIL full_ev%0d got=%h exp=%h", i, mon_q[i], exp[i]); end
        end
        for (int i = 1; i < mon_t.size(); i++) begin
            checks++;
            if (mon_t[i] - mon_t[i-1] < 3) begin failures++; $display("FAIL full_gap%0d got=%0d exp>=3", i, mon_t[i] - mon_t[i-1]); end
        end
        checks++;
        if (packets_sent !== 16'(npk)) begin failures++; $display("FAIL full_pkts got=%0d exp=%0d", packets_sent, npk); end
    endtask

    task automatic test_timeout();
        logic [15:0] acc[$];
        logic [48:0] exp[$];
        int npk;
        int n_ev;
        logic [15:0] v;
        do_reset();
        wiz_available = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            acc.push_back(v);
            send(v);
        end
        repeat (TO + 40) step();
        build_exp(acc, exp, npk);
        checks++;
        if (mon_q.size() != exp.size()) begin failures++; $display("FAIL tmo_events got=%0d exp=%0d", mon_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp[i]) begin failures++; $display("FAIL tmo_ev%0d got=%h exp=%h", i, mon_q[i], exp[i]); end
        end
        checks++;
        if (packets_sent !== 16'(npk)) begin failures++; $display("FAIL tmo_pkts got=%0d exp=%0d", packets_sent, npk); end
        n_ev = mon_q.size();
        repeat (2 * TO + 20) step();
        checks++;
        if (mon_q.size() != n_ev) begin failures++; $display("FAIL tmo_quiet got=%0d exp=%0d", mon_q.size(), n_ev); end
    endtask

    task automatic test_backpressure();
        logic [15:0] acc[$];
        logic [48:0] exp[$];
        int npk;
        int slot;
        int made;
        int drops;
        bit rdy;
        logic [15:0] v;
        do_reset();
        wiz_available = 1'b0;
        slot = 0;
        made = 0;
        drops = 0;
        for (int i = 0; i < 30; i++) begin
            v = 16'($urandom);
            sample_valid = 1'b1;
            sample = v;
            rdy = (slot != 2) || (made < DEPTH);
            checks++;
            if (sample_ready !== rdy) begin failures++; $display("FAIL bp_ready%0d got=%b exp=%b", i, sample_ready, rdy); end
            if (rdy) begin
                acc.push_back(v);
                if (slot == 2) begin slot = 0; made++; end
                else slot++;
            end else begin
                drops++;
            end
            step();
        end
        sample_valid = 1'b0;
        repeat (10) step();
        checks++;
        if (dropped_count !== 16'(drops)) begin failures++; $display("FAIL bp_dropped got=%0d exp=%0d", dropped_count, drops); end
        checks++;
        if (mon_q.size() != 0) begin failures++; $display("FAIL bp_stalled got=%0d exp=0", mon_q.size()); end
        wiz_available = 1'b1;
        repeat (DEPTH * 4 + TO + 60) step();
        build_exp(acc, exp, npk);
        checks++;
        if (mon_q.size() != exp.size()) begin failures++; $display("FAIL bp_events got=%0d exp=%0d", mon_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp[i]) begin failures++; $display("FAIL bp_ev%0d got=%h exp=%h", i, mon_q[i], exp[i]); end
        end
        checks++;
        if (packets_sent !== 16'(npk)) begin failures++; $display("FAIL bp_pkts got=%0d exp=%0d", packets_sent, npk); end
    endtask

    task automatic test_reset_mid_push();
        bit found;
        do_reset();
        wiz_available = 1'b1;
        for (int i = 0; i < 3; i++) send(16'($urandom));
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (wiz_data_valid) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rmid_wait got=timeout exp=push"); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wiz_data_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", wiz_data_valid); end
        checks++;
        if (wiz_flush_requested !== 1'b0) begin failures++; $display("FAIL rmid_flush got=%b exp=0", wiz_flush_requested); end
        checks++;
        if (packets_sent !== 16'h0) begin failures++; $display("FAIL rmid_pkts got=%0d exp=0", packets_sent); end
        repeat (2) step();
        reset_n = 1'b1;
        mon_q.delete();
        mon_t.delete();
        repeat (TO + 40) step();
        checks++;
        if (mon_q.size() != 0) begin failures++; $display("FAIL rmid_after got=%0d exp=0", mon_q.size()); end
    endtask

    task automatic test_random_stream();
        logic [15:0] acc[$];
        logic [48:0] exp[$];
        int npk;
        logic [15:0] v;
        do_reset();
        wiz_pat = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            v = 16'($urandom);
            acc.push_back(v);
            send(v);
            repeat ($urandom_range(1, 3)) step();
        end
        repeat (TO + 100) step();
        wiz_pat = 1'b0;
        build_exp(acc, exp, npk);
        checks++;
        if (mon_q.size() != exp.size()) begin failures++; $display("FAIL rnd_events got=%0d exp=%0d", mon_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp[i]) begin failures++; $display("FAIL rnd_ev%0d got=%h exp=%h", i, mon_q[i], exp[i]); end
        end
        for (int i = 1; i < mon_t.size(); i++) begin
            checks++;
            if (mon_t[i] - mon_t[i-1] < 3) begin failures++; $display("FAIL rnd_gap%0d got=%0d exp>=3", i, mon_t[i] - mon_t[i-1]); end
        end
        checks++;
        if (packets_sent !== 16'(npk)) begin failures++; $display("FAIL rnd_pkts got=%0d exp=%0d", packets_sent, npk); end
        checks++;
        if (dropped_count !== 16'h0) begin failures++; $display("FAIL rnd_dropped got=%0d exp=0", dropped_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_packet();
        test_timeout();
        test_backpressure();
        test_reset_mid_push();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
